xr_port_sched: RTL and testbench

Arbiter and sequencer that shares the single XR memory/register access port between several XR requesters, such as the host register interface, the copper and a future blitter. It sits directly upstream of the XR memory arbiter's `xr_sel`/`xr_ack` port. It latches one request at a time, drives the port with a clean select/ack handshake, and returns the ack and read data to the winning requester. Fixed priority is used, with optional anti-starvation promotion.

---
 rtl/xr_port_sched.sv | 137 +++++++++++++
 tb/tb_xr_port_sched.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xr_port_sched.sv
// Shares the single XR access port between NREQ requesters: fixed priority, one access in flight,
// with optional anti-starvation promotion built only when XR_SCHED_STARVE_EN is defined.
module xr_port_sched #(
    parameter int NREQ         = 3,
    parameter int STARVE_LIMIT = 15
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req_sel_i,
    input  logic [NREQ-1:0]      req_wr_i,
    input  logic [NREQ*16-1:0]   req_addr_i,
    input  logic [NREQ*16-1:0]   req_data_i,
    output logic [NREQ-1:0]      req_ack_o,
    output logic [15:0]          req_data_o,
    output logic [NREQ-1:0]      grant_o,
    output logic                 xr_sel_o,
    output logic                 xr_wr_o,
    output logic [15:0]          xr_addr_o,
    output logic [15:0]          xr_data_o,
    input  logic                 xr_ack_i,
    input  logic [15:0]          xr_data_i,
    output logic [1:0]           dbg_state_o
);

    // Handshake: a requester holds req_sel_i until its one-cycle req_ack_o; the port side holds
    // xr_sel_o and all xr_*_o stable until the one-cycle xr_ack_i, which only counts in ISSUE.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          state;
    logic [NREQ-1:0] excl;
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] pool;
    logic [NREQ-1:0] win_oh;
    logic            win_wr;
    logic [15:0]     win_addr;
    logic [15:0]     win_data;
    logic            launch;

    assign dbg_state_o = state;

    // The requester just acked may still hold its sel during DONE; keep it out of that round.
    assign excl     = (state == S_DONE) ? grant_o : '0;
    assign eligible = req_sel_i & ~excl;

`ifdef XR_SCHED_STARVE_EN
    logic [3:0]      wait_cnt [NREQ];
    logic [NREQ-1:0] starved;

    always_comb begin
        starved = '0;
        for (int k = 0; k < NREQ; k++) begin
            starved[k] = eligible[k] && (wait_cnt[k] == 4'(STARVE_LIMIT));
        end
    end

    assign pool = (|starved) ? starved : eligible;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NREQ; k++) wait_cnt[k] <= 4'd0;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                if (!req_sel_i[k] || grant_o[k] || (launch && win_oh[k])) begin
                    wait_cnt[k] <= 4'd0;
                end else if ((|grant_o) && (wait_cnt[k] != 4'hf)) begin
                    wait_cnt[k] <= wait_cnt[k] + 4'd1;
                end
            end
        end
    end
`else
    assign pool = eligible;
`endif

    // Lowest set index in the pool wins; scanning downward leaves that one last.
    always_comb begin
        win_oh   = '0;
        win_wr   = 1'b0;
        win_addr = '0;
        win_data = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (pool[k]) begin
                win_oh    = '0;
                win_oh[k] = 1'b1;
                win_wr    = req_wr_i[k];
                win_addr  = req_addr_i[16*k +: 16];
                win_data  = req_data_i[16*k +: 16];
            end
        end
    end

    assign launch = ((state == S_IDLE) || (state == S_DONE)) && (|pool);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            req_ack_o  <= '0;
            req_data_o <= '0;
            grant_o    <= '0;
            xr_sel_o   <= 1'b0;
            xr_wr_o    <= 1'b0;
            xr_addr_o  <= '0;
            xr_data_o  <= '0;
        end else begin
            req_ack_o <= '0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (launch) begin
                        xr_sel_o  <= 1'b1;
                        xr_wr_o   <= win_wr;
                        xr_addr_o <= win_addr;
                        xr_data_o <= win_data;
                        grant_o   <= win_oh;
                        state     <= S_ISSUE;
                    end else begin
                        grant_o <= '0;
                        state   <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    if (xr_ack_i) begin
                        req_data_o <= xr_data_i;
                        xr_sel_o   <= 1'b0;
                        req_ack_o  <= grant_o;
                        state      <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xr_port_sched.sv
// Bench for xr_port_sched: directed reset/latency/priority/starvation checks, then random traffic
// scored against per-requester memory models (each requester owns a disjoint address space).
module tb_xr_port_sched;
    localparam int NREQ = 3;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [NREQ-1:0]    req_sel_i, req_wr_i;
    logic [NREQ*16-1:0] req_addr_i, req_data_i;
    logic [NREQ-1:0]    req_ack_o, grant_o;
    logic [15:0]        req_data_o, xr_addr_o, xr_data_o, xr_data_i;
    logic               xr_sel_o, xr_wr_o, xr_ack_i;
    logic [1:0]         dbg_state_o;

    always #5 clk = ~clk;

    xr_port_sched #(.NREQ(NREQ), .STARVE_LIMIT(15)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_sel_i(req_sel_i), .req_wr_i(req_wr_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
        .req_ack_o(req_ack_o), .req_data_o(req_data_o), .grant_o(grant_o),
        .xr_sel_o(xr_sel_o), .xr_wr_o(xr_wr_o), .xr_addr_o(xr_addr_o), .xr_data_o(xr_data_o),
        .xr_ack_i(xr_ack_i), .xr_data_i(xr_data_i), .dbg_state_o(dbg_state_o)
    );

    int n_vec = 0;
    int n_err = 0;

    // scoreboard: {wr, addr, write data or expected read data} per requester
    logic [32:0] exp_q [NREQ][$];
    logic [15:0] model_mem [logic [15:0]];
    logic [15:0] mem [logic [15:0]];

    int  left [NREQ];
    int  gap [NREQ];
    bit  busy [NREQ];
    bit  drop_nxt [NREQ];
    int  ds_cnt = -1;
    bit  ds_slow = 1'b0;
    bit  snap_v = 1'b0;
    bit  ack_pend = 1'b0;
    int  ack_k = 0;
    int  cur_k = 0;
    logic [35:0] snap;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return a ^ 16'ha5c3;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ack"}, req_ack_o, 0);
        chk({tag, "_grant"}, grant_o, 0);
        chk({tag, "_xr_sel"}, xr_sel_o, 0);
        chk({tag, "_xr_wr"}, xr_wr_o, 0);
        chk({tag, "_xr_addr"}, xr_addr_o, 0);
        chk({tag, "_xr_data"}, xr_data_o, 0);
        chk({tag, "_req_data"}, req_data_o, 0);
        chk({tag, "_state_idle"}, dbg_state_o, 0);
    endtask

    task automatic set_req(input int k, input logic wr, input logic [15:0] a, input logic [15:0] d);
        req_wr_i[k] = wr;
        req_addr_i[16*k +: 16] = a;
        req_data_i[16*k +: 16] = d;
        req_sel_i[k] = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        req_sel_i = '0;
        xr_ack_i = 1'b0;
        ds_cnt = -1;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // downstream port: random latency, memory behind it, one-cycle ack pulse
    task automatic ds_step();
        if (xr_ack_i) begin
            xr_ack_i = 1'b0;
        end else if (xr_sel_o) begin
            if (ds_cnt < 0)
                ds_cnt = !ds_slow ? 0 : ($urandom_range(0, 7) == 0) ? 9 : int'($urandom_range(0, 2));
            if (ds_cnt == 0) begin
                xr_ack_i = 1'b1;
                if (xr_wr_o) begin
                    mem[xr_addr_o] = xr_data_o;
                    xr_data_i = 16'($urandom);
                end else begin
                    xr_data_i = mem.exists(xr_addr_o) ? mem[xr_addr_o] : init_val(xr_addr_o);
                end
                ds_cnt = -1;
                ack_pend = 1'b1;
                ack_k = cur_k;
            end else begin
                ds_cnt--;
            end
        end
    endtask

    task automatic mon_step();
        logic [32:0] e;
        int k;
        if (ack_pend) begin
            chk("req_ack", req_ack_o, 64'(1) << ack_k);
            chk("sel_drop", xr_sel_o, 0);
            if (exp_q[ack_k].size() > 0) begin
                e = exp_q[ack_k].pop_front();
                if (!e[32]) chk("rd_data", req_data_o, e[15:0]);
            end
            ack_pend = 1'b0;
        end else begin
            chk("no_ack", req_ack_o, 0);
        end
        if (xr_sel_o) begin
            if (!snap_v) begin
                k = int'(xr_addr_o[15:14]);
                if (k > NREQ - 1) begin
                    chk("addr_space", 64'(k), 64'(NREQ - 1));
                end else begin
                    cur_k = k;
                    chk("grant", grant_o, 64'(1) << k);
                    chk("access_expected", exp_q[k].size() > 0, 1);
                    if (exp_q[k].size() > 0) begin
                        e = exp_q[k][0];
                        chk("xr_wr", xr_wr_o, e[32]);
                        chk("xr_addr", xr_addr_o, e[31:16]);
                        if (e[32]) chk("xr_data", xr_data_o, e[15:0]);
                    end
                end
                snap = {grant_o, xr_wr_o, xr_addr_o, xr_data_o};
                snap_v = 1'b1;
            end else begin
                chk("stall_hold", {grant_o, xr_wr_o, xr_addr_o, xr_data_o}, snap);
            end
        end else begin
            snap_v = 1'b0;
        end
    endtask

    task automatic issue(input int k);
        logic [15:0] a, d, ev;
        logic w;
        a = {2'(k), 11'd0, 3'($urandom_range(0, 7))};
        w = 1'($urandom_range(0, 1));
        d = 16'($urandom);
        if (w) begin
            model_mem[a] = d;
            ev = d;
        end else begin
            ev = model_mem.exists(a) ? model_mem[a] : init_val(a);
        end
        exp_q[k].push_back({w, a, ev});
        set_req(k, w, a, d);
        busy[k] = 1'b1;
        left[k]--;
    endtask

    task automatic stim_step();
        for (int k = 0; k < NREQ; k++) begin
            if (req_ack_o[k] && busy[k]) begin
                busy[k] = 1'b0;
                drop_nxt[k] = 1'b1;
                gap[k] = $urandom_range(0, 4);
            end else if (drop_nxt[k]) begin
                drop_nxt[k] = 1'b0;
                if (gap[k] == 0 && left[k] > 0) issue(k);
                else req_sel_i[k] = 1'b0;
            end else if (!busy[k]) begin
                if (gap[k] > 0) gap[k]--;
                else if (left[k] > 0) issue(k);
            end
        end
    endtask

    function automatic bit all_done();
        bit r = 1'b1;
        for (int k = 0; k < NREQ; k++)
            if (left[k] > 0 || busy[k] || drop_nxt[k]) r = 1'b0;
        return r;
    endfunction

    initial begin
        int first2;
        reset_n = 1'b0;
        req_sel_i = '0; req_wr_i = '0; req_addr_i = '0; req_data_i = '0;
        xr_ack_i = 1'b0; xr_data_i = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk_all_zero("por");

        // single read, requester 1, port acks in cycle 2
        set_req(1, 1'b0, 16'h8003, 16'h0000);
        @(negedge clk);
        chk("rd_c1_sel", xr_sel_o, 1);
        chk("rd_c1_addr", xr_addr_o, 16'h8003);
        chk("rd_c1_wr", xr_wr_o, 0);
        chk("rd_c1_grant", grant_o, 3'b010);
        @(negedge clk);
        chk("rd_c2_sel", xr_sel_o, 1);
        xr_ack_i = 1'b1; xr_data_i = 16'hbeef;
        @(negedge clk);
        xr_ack_i = 1'b0;
        chk("rd_c3_ack", req_ack_o, 3'b010);
        chk("rd_c3_data", req_data_o, 16'hbeef);
        chk("rd_c3_sel", xr_sel_o, 0);
        req_sel_i = '0;
        @(negedge clk);
        chk("rd_c4_ack", req_ack_o, 0);
        chk("rd_c4_grant", grant_o, 0);

        // priority: 0 and 2 together, 2 granted straight from DONE
        set_req(0, 1'b1, 16'h0010, 16'h1234);
        set_req(2, 1'b0, 16'h8020, 16'h0000);
        @(negedge clk);
        chk("pri_grant0", grant_o, 3'b001);
        chk("pri_wr0", xr_wr_o, 1);
        chk("pri_addr0", xr_addr_o, 16'h0010);
        chk("pri_data0", xr_data_o, 16'h1234);
        xr_ack_i = 1'b1; xr_data_i = 16'h0000;
        @(negedge clk);
        xr_ack_i = 1'b0;
        chk("pri_ack0", req_ack_o, 3'b001);
        chk("pri_done_sel", xr_sel_o, 0);
        @(negedge clk);
        req_sel_i[0] = 1'b0;
        chk("pri_grant2", grant_o, 3'b100);
        chk("pri_sel2", xr_sel_o, 1);
        chk("pri_addr2", xr_addr_o, 16'h8020);
        xr_ack_i = 1'b1; xr_data_i = 16'h5555;
        @(negedge clk);
        xr_ack_i = 1'b0;
        chk("pri_ack2", req_ack_o, 3'b100);
        chk("pri_data2", req_data_o, 16'h5555);
        req_sel_i = '0;
        @(negedge clk);
        chk("pri_idle", dbg_state_o, 0);

        // reset while an access is outstanding, then a stale ack
        set_req(1, 1'b1, 16'h4444, 16'hffff);
        @(negedge clk);
        chk("mid_issue_sel", xr_sel_o, 1);
        reset_n = 1'b0;
        #1;
        chk_all_zero("mid_rst");
        req_sel_i = '0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        xr_ack_i = 1'b1; xr_data_i = 16'h7777;
        @(negedge clk);
        xr_ack_i = 1'b0;
        chk("stale_ack", req_ack_o, 0);
        chk("stale_data", req_data_o, 0);
        chk("stale_state", dbg_state_o, 0);
        @(negedge clk);
        chk("stale_ack2", req_ack_o, 0);

        // starvation: all three requesting continuously, fast port
        ds_slow = 1'b0;
        first2 = -1;
        set_req(0, 1'b0, 16'h0001, 16'h0); set_req(1, 1'b0, 16'h4001, 16'h0); set_req(2, 1'b0, 16'h8001, 16'h0);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            ds_step();
            if (grant_o[2] && first2 < 0) first2 = c;
        end
`ifdef XR_SCHED_STARVE_EN
        chk("starve_promoted", (first2 >= 0) && (first2 < 40), 1);
`else
        chk("starve_never_granted", first2 >= 0, 0);
`endif
        req_sel_i = '0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            ds_step();
        end
        do_reset();

        // random traffic against the scoreboard
        ds_slow = 1'b1;
        snap_v = 1'b0;
        ack_pend = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            left[k] = 40; gap[k] = $urandom_range(0, 3); busy[k] = 1'b0; drop_nxt[k] = 1'b0;
        end
        for (int cyc = 0; cyc < 20000 && !all_done(); cyc++) begin
            @(negedge clk);
            mon_step();
            ds_step();
            stim_step();
        end
        repeat (3) begin
            @(negedge clk);
            mon_step();
            ds_step();
        end
        for (int k = 0; k < NREQ; k++) begin
            chk("all_issued", left[k], 0);
            chk("queue_drained", exp_q[k].size(), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
